// File: rtl/t07_spi_tft_pkg.sv
// t07_spi_tft_pkg: shared FSM state type, command width and common TFT command codes
package t07_spi_tft_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   localparam int CMD_W = 8;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

endpackage

// File: rtl/t07_spi_clkgen.sv
// t07_spi_clkgen: SCLK divider that runs only while enabled and flags the leading/trailing edges
module t07_spi_clkgen #(
   parameter int CLK_DIV = 2,
   parameter bit CPOL    = 1'b0
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   output logic sclk,
   output logic lead,
   output logic trail
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          tick;

   // a strobe fires in the cycle whose closing edge moves sclk; its direction names the edge
   always_comb begin
      tick  = en && (cnt == LAST);
      lead  = tick && (sclk == CPOL);
      trail = tick && (sclk != CPOL);
   end

   // half-period counter; disabling parks sclk at its idle level with the count cleared
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt  <= '0;
         sclk <= CPOL;
      end else if (!en) begin
         cnt  <= '0;
         sclk <= CPOL;
      end else begin
         cnt  <= tick ? '0 : cnt + CW'(1);
         sclk <= tick ? ~sclk : sclk;
      end
   end

endmodule

// File: rtl/t07_spi_tft_master.sv
// t07_spi_tft_master: SPI write master sending a command byte then up to DATA_W/8 data bytes per CS frame
module t07_spi_tft_master
   import t07_spi_tft_pkg::*;
#(
   parameter int  DATA_W   = 32,
   parameter int  CLK_DIV  = 2,
   parameter bit  CPOL     = 1'b0,
   parameter int  CS_SETUP = 1,
   parameter int  CS_HOLD  = 1,
   localparam int NB_W     = $clog2(DATA_W/8 + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              wi,
   input  logic [31:0]       address,
   input  logic [DATA_W-1:0] data,
   input  logic [NB_W-1:0]   nbytes,
   output logic              busy,
   output logic              ack,
   output logic              chipSelect,
   output logic              sclk,
   output logic              bitData,
   output logic              dcx
);

   localparam int SR_W = CMD_W + DATA_W;
   localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [NB_W-1:0] NB_LAST = NB_W'(DATA_W/8);
   localparam logic [TW-1:0]   SU_LAST = TW'(CS_SETUP - 1);
   localparam logic [TW-1:0]   HO_LAST = TW'(CS_HOLD - 1);

   state_t            state, nxt;
   logic [TW-1:0]     tmr;
   logic [SR_W-1:0]   sr;
   logic [2:0]        bit_cnt;
   logic [NB_W-1:0]   byte_cnt, nb, n_cl;
   logic [DATA_W-1:0] dal;
   logic              dcx_r, sclk_i, lead, trail;
   logic              accept, byte_end, frame_end;
   logic              unused_bits;

   t07_spi_clkgen #(.CLK_DIV(CLK_DIV), .CPOL(CPOL)) u_clkgen (
      .clk   (clk),
      .nrst  (nrst),
      .en    (state == SHIFT),
      .sclk  (sclk_i),
      .lead  (lead),
      .trail (trail)
   );

   // request decode: clamp byte count and left-align the bytes that will actually be sent
   always_comb begin
      accept      = (state == IDLE) && wi;
      n_cl        = (nbytes > NB_LAST) ? NB_LAST : nbytes;
      dal         = data << {NB_LAST - n_cl, 3'b000};
      byte_end    = trail && (bit_cnt == 3'd7);
      frame_end   = byte_end && (byte_cnt == nb);
      unused_bits = ^{address[31:8], lead};
   end

   // state register with a phase timer that restarts on every state change
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         tmr   <= '0;
      end else begin
         state <= nxt;
         tmr   <= (nxt != state) ? '0 : tmr + TW'(1);
      end
   end

   // next-state logic; wi only matters in IDLE
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (wi) nxt = SETUP;
         SETUP:   if (tmr == SU_LAST) nxt = SHIFT;
         SHIFT:   if (frame_end) nxt = HOLD;
         HOLD:    if (tmr == HO_LAST) nxt = DONE;
         default: nxt = IDLE;
      endcase
   end

   // shift register and bit/byte counters advance on each trailing sclk edge
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sr       <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         nb       <= '0;
         dcx_r    <= 1'b1;
      end else if (accept) begin
         sr       <= {address[7:0], dal};
         bit_cnt  <= '0;
         byte_cnt <= '0;
         nb       <= n_cl;
         dcx_r    <= 1'b0;
      end else if (state == SHIFT && trail) begin
         sr      <= {sr[SR_W-2:0], 1'b0};
         bit_cnt <= bit_cnt + 3'd1;
         if (byte_end) begin
            byte_cnt <= frame_end ? '0 : byte_cnt + NB_W'(1);
            dcx_r    <= frame_end ? dcx_r : 1'b1;
         end
      end
   end

   // pin drive: CS low across setup/shift/hold, MOSI and DCX parked outside the frame
   always_comb begin
      busy       = state != IDLE;
      ack        = state == DONE;
      chipSelect = !(state == SETUP || state == SHIFT || state == HOLD);
      bitData    = chipSelect ? 1'b0 : sr[SR_W-1];
      dcx        = chipSelect ? 1'b1 : dcx_r;
      sclk       = sclk_i;
   end

endmodule

// File: tb/tb_t07_spi_tft_master.sv
// tb_t07_spi_tft_master: two parameterisations checked every cycle against a frame-level model
module tb_t07_spi_tft_master;

   logic        clk = 1'b0, nrst = 1'b0, wi = 1'b0;
   logic [31:0] address = '0, data = '0;
   logic [2:0]  nbytes = '0;
   logic [1:0]  busy, ack, cs, sclk, mosi, dcx;

   int          checks = 0, failures = 0;
   bit          act [2];
   int          t [2];
   logic [7:0]  mcmd [2];
   logic [31:0] mdat [2];
   int          mn [2];
   int          ackcnt [2];
   logic [63:0] cap [2], capd [2];
   int          nb [2];
   logic        psclk [2] = '{1'b0, 1'b1};
   logic        pbusy [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   t07_spi_tft_master #(.DATA_W(32), .CLK_DIV(2), .CPOL(1'b0), .CS_SETUP(1), .CS_HOLD(1)) u0 (
      .clk(clk), .nrst(nrst), .wi(wi), .address(address), .data(data), .nbytes(nbytes),
      .busy(busy[0]), .ack(ack[0]), .chipSelect(cs[0]), .sclk(sclk[0]), .bitData(mosi[0]), .dcx(dcx[0]));

   t07_spi_tft_master #(.DATA_W(32), .CLK_DIV(1), .CPOL(1'b1), .CS_SETUP(2), .CS_HOLD(3)) u1 (
      .clk(clk), .nrst(nrst), .wi(wi), .address(address), .data(data), .nbytes(nbytes),
      .busy(busy[1]), .ack(ack[1]), .chipSelect(cs[1]), .sclk(sclk[1]), .bitData(mosi[1]), .dcx(dcx[1]));

   function automatic int cd(input int g);   return g == 0 ? 2 : 1; endfunction
   function automatic logic cp(input int g); return g == 0 ? 1'b0 : 1'b1; endfunction
   function automatic int su(input int g);   return g == 0 ? 1 : 2; endfunction
   function automatic int ho(input int g);   return g == 0 ? 1 : 3; endfunction
   function automatic int flen(input int g, input int n);
      return 1 + su(g) + 16*cd(g)*(1+n) + ho(g);
   endfunction

   // expected {busy,ack,cs,sclk,mosi,dcx} for instance g at frame offset t[g]
   function automatic logic [5:0] expv(input int g, output logic [5:0] m);
      int u, b, by;
      logic [7:0] byt;
      m = 6'b111111;
      if (!act[g]) return {1'b0, 1'b0, 1'b1, cp(g), 1'b0, 1'b1};
      if (t[g] == flen(g, mn[g])) return {1'b1, 1'b1, 1'b1, cp(g), 1'b0, 1'b1};
      if (t[g] <= su(g)) return {1'b1, 1'b0, 1'b0, cp(g), mcmd[g][7], 1'b0};
      u = t[g] - 1 - su(g);
      if (u >= 16*cd(g)*(1+mn[g])) begin
         m = 6'b111101;
         return {1'b1, 1'b0, 1'b0, cp(g), 1'b0, mn[g] != 0};
      end
      b   = u / (2*cd(g));
      by  = b / 8;
      byt = (by == 0) ? mcmd[g] : 8'(mdat[g] >> (8*(mn[g]-by)));
      return {1'b1, 1'b0, 1'b0, cp(g) ^ (((u/cd(g)) % 2) == 1), byt[7 - b%8], by != 0};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // one clock: model advances at the edge, outputs compared and captured at the falling edge
   task automatic cycle();
      logic [5:0] e, m, gv;
      @(posedge clk);
      for (int g = 0; g < 2; g++) begin
         if (!nrst) act[g] = 1'b0;
         else if (act[g]) begin
            if (t[g] == flen(g, mn[g])) act[g] = 1'b0;
            else t[g]++;
         end else if (wi) begin
            act[g]  = 1'b1;
            t[g]    = 1;
            mcmd[g] = address[7:0];
            mdat[g] = data;
            mn[g]   = (nbytes > 3'd4) ? 4 : int'(nbytes);
         end
      end
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         gv = {busy[g], ack[g], cs[g], sclk[g], mosi[g], dcx[g]};
         e  = expv(g, m);
         checks++;
         if ((gv & m) !== (e & m)) begin
            failures++;
            $display("FAIL pins inst=%0d t=%0d got=%b exp=%b mask=%b", g, t[g], gv, e, m);
         end
         ackcnt[g] += int'(ack[g]);
         if (busy[g] && !pbusy[g]) begin
            cap[g]  = '0;
            capd[g] = '0;
            nb[g]   = 0;
         end
         if (sclk[g] != psclk[g] && sclk[g] != cp(g)) begin
            cap[g]  = {cap[g][62:0], mosi[g]};
            capd[g] = {capd[g][62:0], dcx[g]};
            nb[g]++;
         end
         psclk[g] = sclk[g];
         pbusy[g] = busy[g];
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy != 2'b00 && n < 1000) begin
         cycle();
         n++;
      end
      chk("idle_timeout", {62'd0, busy}, 64'd0);
   endtask

   task automatic run_frame(input logic [7:0] c, input logic [31:0] d, input logic [2:0] n,
                            output int lat0, output int lat1);
      int cnt;
      wait_idle();
      address = {$urandom_range(0, 32'h00FF_FFFF), c};
      data    = d;
      nbytes  = n;
      wi      = 1'b1;
      cycle();
      wi   = 1'b0;
      cnt  = 1;
      lat0 = -1;
      lat1 = -1;
      while ((lat0 < 0 || lat1 < 0) && cnt < 600) begin
         cycle();
         cnt++;
         if (ack[0] && lat0 < 0) lat0 = cnt;
         if (ack[1] && lat1 < 0) lat1 = cnt;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int l0, l1, a0, a1;
      repeat (3) cycle();
      chk("rst_cs", {62'd0, cs}, 64'd3);
      chk("rst_sclk", {62'd0, sclk}, 64'd2);
      chk("rst_busy_ack", {60'd0, busy, ack}, 64'd0);
      chk("rst_dcx_mosi", {60'd0, dcx, mosi}, 64'hC);
      nrst = 1'b1;
      repeat (2) cycle();

      run_frame(8'h2C, $urandom, 3'd0, l0, l1);
      chk("cmd_lat0", l0, 35);
      chk("cmd_lat1", l1, 22);
      chk("cmd_nbits", nb[0], 8);
      chk("cmd_mosi0", cap[0][7:0], 8'h2C);
      chk("cmd_dcx0", capd[0][7:0], 8'h00);
      chk("cmd_mosi1", cap[1][7:0], 8'h2C);

      run_frame(8'h2C, 32'h0000F800, 3'd2, l0, l1);
      chk("pix_lat0", l0, 99);
      chk("pix_lat1", l1, 54);
      chk("pix_nbits0", nb[0], 24);
      chk("pix_mosi0", cap[0][23:0], 24'h2CF800);
      chk("pix_dcx0", capd[0][23:0], 24'h00FFFF);
      chk("pix_nbits1", nb[1], 24);
      chk("pix_mosi1", cap[1][23:0], 24'h2CF800);

      run_frame(8'h2C, 32'hAAAA5555, 3'd4, l0, l1);
      chk("full_lat0", l0, 163);
      chk("full_lat1", l1, 86);
      chk("full_mosi0", cap[0][39:0], 40'h2CAAAA5555);
      chk("full_dcx0", capd[0][39:0], 40'h00FFFFFFFF);

      run_frame(8'h2A, 32'hAAAA5555, 3'd7, l0, l1);
      chk("clamp_lat0", l0, 163);
      chk("clamp_nbits1", nb[1], 40);
      chk("clamp_mosi1", cap[1][39:0], 40'h2AAAAA5555);

      wait_idle();
      a0 = ackcnt[0];
      address = 32'h2B; data = $urandom; nbytes = 3'd1; wi = 1'b1;
      cycle();
      for (int i = 0; i < 60; i++) begin
         wi = (i % 7 == 3);
         cycle();
      end
      wi = 1'b0;
      wait_idle();
      chk("busy_ignored", ackcnt[0] - a0, 1);

      a0 = ackcnt[0];
      address = 32'h2C; nbytes = 3'd0; wi = 1'b1;
      repeat (80) cycle();
      wi = 1'b0;
      wait_idle();
      chk("b2b_acks", ackcnt[0] - a0, 3);

      address = 32'h2C; data = $urandom; nbytes = 3'd2; wi = 1'b1;
      cycle();
      wi = 1'b0;
      repeat (40) cycle();
      a0 = ackcnt[0];
      a1 = ackcnt[1];
      nrst = 1'b0;
      #1;
      chk("rst_mid_cs", {62'd0, cs}, 64'd3);
      chk("rst_mid_sclk", {62'd0, sclk}, 64'd2);
      chk("rst_mid_busy_ack", {60'd0, busy, ack}, 64'd0);
      repeat (2) cycle();
      nrst = 1'b1;
      repeat (100) cycle();
      chk("rst_no_ack", ackcnt[0] - a0 + ackcnt[1] - a1, 0);

      a0 = ackcnt[0];
      for (int i = 0; i < 3000; i++) begin
         address = $urandom;
         data    = $urandom;
         nbytes  = 3'($urandom_range(0, 7));
         wi      = ($urandom_range(0, 3) == 0);
         cycle();
      end
      wi = 1'b0;
      wait_idle();
      chk("rand_acks_seen", ackcnt[0] > a0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
